// File: rtl/blob_bbox.sv
// blob_bbox: per-frame bounding box of object cells in the decimated corrosion cell stream.
//
// Cells arrive in raster order, one per i_valid strobe, GRID_X cells per row and GRID_Y rows
// per frame. The box is reported in cell coordinates, together with the object cell count and
// a found flag. o_done pulses for one cycle, and the outputs are updated in that same cycle.
// The outputs then hold until the next o_done.
//
// Ports:
//   sys_clk  system clock
//   sys_rst  synchronous active-high reset
//   i_valid  cell strobe from the corrosion stage
//   i_wb     cell value; an object cell has i_wb == OBJ_LEVEL
//   o_done   one-cycle pulse, new frame result on outputs
//   o_found  object present in last reported frame
//   o_x1/o_x2, o_y1/o_y2  leftmost/rightmost column, top/bottom row of object cells
//   o_cnt    object cell count of last frame (saturating)
//
// Optional build macro BBOX_DEBOUNCE_EN: when defined, o_found must see DEB_FRAMES
// consecutive raw-found frames before it rises. It must see DEB_FRAMES consecutive raw-miss
// frames before it falls.

`ifndef CORROSION_DX
`define CORROSION_DX 8
`endif
`ifndef CORROSION_DY
`define CORROSION_DY 6
`endif

module blob_bbox #(
    parameter int unsigned GRID_X     = `CORROSION_DX,
    parameter int unsigned GRID_Y     = `CORROSION_DY,
    parameter int unsigned CELL_W     = 8,
    parameter int unsigned CNT_W      = 16,
    parameter logic        OBJ_LEVEL  = 1'b0,
    parameter int unsigned MIN_CELLS  = 4,
    parameter int unsigned DEB_FRAMES = 3
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              i_valid,
    input  logic              i_wb,
    output logic              o_done,
    output logic              o_found,
    output logic [CELL_W-1:0] o_x1,
    output logic [CELL_W-1:0] o_x2,
    output logic [CELL_W-1:0] o_y1,
    output logic [CELL_W-1:0] o_y2,
    output logic [CNT_W-1:0]  o_cnt
);

    localparam logic [CELL_W-1:0] X_LAST = CELL_W'(GRID_X - 1);
    localparam logic [CELL_W-1:0] Y_LAST = CELL_W'(GRID_Y - 1);
    localparam logic [CNT_W-1:0]  CNT_MIN = CNT_W'(MIN_CELLS);

    // Elaboration-time parameter sanity checks.
    if (DEB_FRAMES < 1) begin : g_bad_deb
        $error("blob_bbox: DEB_FRAMES must be at least 1");
    end
    if ((GRID_X < 1) || (GRID_Y < 1) || (GRID_X > (1 << CELL_W)) || (GRID_Y > (1 << CELL_W)))
    begin : g_bad_grid
        $error("blob_bbox: grid does not fit in CELL_W");
    end

    typedef enum logic [0:0] {StAccum, StCommit} state_e;

    state_e            state_q, state_d;
    logic [CELL_W-1:0] cx_q, cx_d, cy_q, cy_d;
    logic [CELL_W-1:0] min_x_q, min_x_d, max_x_q, max_x_d;
    logic [CELL_W-1:0] min_y_q, min_y_d, max_y_q, max_y_d;
    logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
    logic              seen_q, seen_d;
    logic [CELL_W-1:0] x1_q, x1_d, x2_q, x2_d, y1_q, y1_d, y2_q, y2_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              found_q, found_d;

    // Accumulator state with the current cell folded in.
    logic [CELL_W-1:0] f_min_x, f_max_x, f_min_y, f_max_y;
    logic [CNT_W-1:0]  f_cnt;
    logic              f_seen;
    logic              is_obj, last_cell, raw_found;

`ifdef BBOX_DEBOUNCE_EN
    localparam int unsigned DEB_W = $clog2(DEB_FRAMES + 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_FRAMES);
    logic [DEB_W-1:0] hit_q, hit_d, miss_q, miss_d;
`endif

    always_comb begin
        is_obj    = i_valid && (i_wb == OBJ_LEVEL);
        last_cell = i_valid && (cx_q == X_LAST) && (cy_q == Y_LAST);

        cx_d = cx_q;
        cy_d = cy_q;
        if (i_valid) begin
            if (cx_q == X_LAST) begin
                cx_d = '0;
                cy_d = (cy_q == Y_LAST) ? '0 : cy_q + 1'b1;
            end else begin
                cx_d = cx_q + 1'b1;
            end
        end

        f_min_x = min_x_q;
        f_max_x = max_x_q;
        f_min_y = min_y_q;
        f_max_y = max_y_q;
        f_cnt   = acc_cnt_q;
        f_seen  = seen_q;
        if (is_obj) begin
            if (!seen_q) begin
                f_min_x = cx_q;
                f_max_x = cx_q;
                f_min_y = cy_q;
                f_max_y = cy_q;
                f_cnt   = CNT_W'(1);
                f_seen  = 1'b1;
            end else begin
                if (cx_q < min_x_q) f_min_x = cx_q;
                if (cx_q > max_x_q) f_max_x = cx_q;
                if (cy_q < min_y_q) f_min_y = cy_q;
                if (cy_q > max_y_q) f_max_y = cy_q;
                if (acc_cnt_q != '1) f_cnt = acc_cnt_q + 1'b1;
            end
        end
        raw_found = f_seen && (f_cnt >= CNT_MIN);

        min_x_d   = f_min_x;
        max_x_d   = f_max_x;
        min_y_d   = f_min_y;
        max_y_d   = f_max_y;
        acc_cnt_d = f_cnt;
        seen_d    = f_seen;

        x1_d    = x1_q;
        x2_d    = x2_q;
        y1_d    = y1_q;
        y2_d    = y2_q;
        cnt_d   = cnt_q;
        found_d = found_q;
`ifdef BBOX_DEBOUNCE_EN
        hit_d  = hit_q;
        miss_d = miss_q;
`endif

        // The result registers load on the edge that enters StCommit, so the frame result is
        // visible during the o_done cycle. The accumulators are cleared on the same edge, so
        // a cell arriving during StCommit starts the next frame from a clean state.
        if (last_cell) begin
            x1_d  = f_seen ? f_min_x : '0;
            x2_d  = f_seen ? f_max_x : '0;
            y1_d  = f_seen ? f_min_y : '0;
            y2_d  = f_seen ? f_max_y : '0;
            cnt_d = f_seen ? f_cnt : '0;
`ifdef BBOX_DEBOUNCE_EN
            if (raw_found) begin
                hit_d  = (hit_q == DEB_MAX) ? hit_q : hit_q + 1'b1;
                miss_d = '0;
                if (hit_d == DEB_MAX) found_d = 1'b1;
            end else begin
                miss_d = (miss_q == DEB_MAX) ? miss_q : miss_q + 1'b1;
                hit_d  = '0;
                if (miss_d == DEB_MAX) found_d = 1'b0;
            end
`else
            found_d = raw_found;
`endif
            min_x_d   = '0;
            max_x_d   = '0;
            min_y_d   = '0;
            max_y_d   = '0;
            acc_cnt_d = '0;
            seen_d    = 1'b0;
        end

        // A 1x1 grid commits on every cell.
        state_d = last_cell ? StCommit : StAccum;
        o_done  = (state_q == StCommit);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= StAccum;
            cx_q      <= '0;
            cy_q      <= '0;
            min_x_q   <= '0;
            max_x_q   <= '0;
            min_y_q   <= '0;
            max_y_q   <= '0;
            acc_cnt_q <= '0;
            seen_q    <= 1'b0;
            x1_q      <= '0;
            x2_q      <= '0;
            y1_q      <= '0;
            y2_q      <= '0;
            cnt_q     <= '0;
            found_q   <= 1'b0;
`ifdef BBOX_DEBOUNCE_EN
            hit_q     <= '0;
            miss_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            min_x_q   <= min_x_d;
            max_x_q   <= max_x_d;
            min_y_q   <= min_y_d;
            max_y_q   <= max_y_d;
            acc_cnt_q <= acc_cnt_d;
            seen_q    <= seen_d;
            x1_q      <= x1_d;
            x2_q      <= x2_d;
            y1_q      <= y1_d;
            y2_q      <= y2_d;
            cnt_q     <= cnt_d;
            found_q   <= found_d;
`ifdef BBOX_DEBOUNCE_EN
            hit_q     <= hit_d;
            miss_q    <= miss_d;
`endif
        end
    end

    assign o_found = found_q;
    assign o_x1    = x1_q;
    assign o_x2    = x2_q;
    assign o_y1    = y1_q;
    assign o_y2    = y2_q;
    assign o_cnt   = cnt_q;

endmodule

// File: tb/tb_blob_bbox.sv
// Testbench for blob_bbox on an 8x6 cell grid. Frames come from a vector table. Expected
// results are queued when the last cell of a frame is driven. They are checked when o_done
// fires, and the check includes the one-cycle latency.

module tb_blob_bbox;

    localparam int GX = 8;
    localparam int GY = 6;
    localparam int NCELL = GX * GY;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        i_valid;
    logic        i_wb;
    logic        o_done;
    logic        o_found;
    logic [7:0]  o_x1, o_x2, o_y1, o_y2;
    logic [15:0] o_cnt;

    blob_bbox #(
        .GRID_X     (GX),
        .GRID_Y     (GY),
        .CELL_W     (8),
        .CNT_W      (16),
        .OBJ_LEVEL  (1'b0),
        .MIN_CELLS  (2),
        .DEB_FRAMES (3)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .i_valid (i_valid),
        .i_wb    (i_wb),
        .o_done  (o_done),
        .o_found (o_found),
        .o_x1    (o_x1),
        .o_x2    (o_x2),
        .o_y1    (o_y1),
        .o_y2    (o_y2),
        .o_cnt   (o_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // mask bit y*GX+x set = object cell at (x,y)
    typedef struct {
        logic [NCELL-1:0] mask;
        bit               gaps;
        bit               b2b;
        int               x1, x2, y1, y2, cnt;
        bit               found;
    } vec_t;

    typedef struct {
        int x1, x2, y1, y2, cnt;
        bit found;
        int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    // Checker, sampled on the falling edge.
    always @(negedge sys_clk) begin
        if (o_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("x1", int'(o_x1), e.x1);
                chk("x2", int'(o_x2), e.x2);
                chk("y1", int'(o_y1), e.y1);
                chk("y2", int'(o_y2), e.y2);
                chk("cnt", int'(o_cnt), e.cnt);
                chk("found", int'(o_found), int'(e.found));
            end
        end
    end

`ifdef BBOX_DEBOUNCE_EN
    int m_hit = 0, m_miss = 0;
    bit m_found = 0;
    function automatic bit found_for(input bit raw);
        if (raw) begin
            m_miss = 0;
            if (m_hit < 3) m_hit++;
            if (m_hit == 3) m_found = 1;
        end else begin
            m_hit = 0;
            if (m_miss < 3) m_miss++;
            if (m_miss == 3) m_found = 0;
        end
        return m_found;
    endfunction
    task automatic model_reset();
        m_hit = 0; m_miss = 0; m_found = 0;
    endtask
`else
    function automatic bit found_for(input bit raw);
        return raw;
    endfunction
    task automatic model_reset();
    endtask
`endif

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sys_clk); #1;
            i_valid = 1'b0;
            i_wb    = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_frame(input vec_t v, input bit found_exp);
        exp_t x;
        for (int i = 0; i < NCELL; i++) begin
            if (v.gaps && i != 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            @(posedge sys_clk); #1;
            i_valid = 1'b1;
            i_wb    = ~v.mask[i];
            if (i == NCELL - 1) begin
                x.x1 = v.x1; x.x2 = v.x2; x.y1 = v.y1; x.y2 = v.y2; x.cnt = v.cnt;
                x.found = found_exp;
                x.cyc = cyc + 1;
                sb.push_back(x);
            end
        end
    endtask

    task automatic do_reset();
        @(posedge sys_clk); #1;
        sys_rst = 1'b1;
        i_valid = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        model_reset();
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    vec_t vecs[5];
    vec_t vrst;

    initial begin
        //                mask                 gaps b2b x1 x2 y1 y2 cnt found
        vecs[0] = '{48'h0008_0000_2400, 1'b0, 1'b0, 2, 5, 1, 4, 3,  1'b1};
        vecs[1] = '{48'h0000_0000_0000, 1'b1, 1'b0, 0, 0, 0, 0, 0,  1'b0};
        vecs[2] = '{48'h8000_0000_0000, 1'b1, 1'b0, 7, 7, 5, 5, 1,  1'b0};
        vecs[3] = '{48'hFFFF_FFFF_FFFF, 1'b1, 1'b1, 0, 7, 0, 5, 48, 1'b1};
        vecs[4] = '{48'h0000_0040_0001, 1'b0, 1'b0, 0, 6, 0, 2, 2,  1'b1};
        vrst    = '{48'h0000_0002_0200, 1'b0, 1'b0, 1, 1, 1, 2, 2,  1'b1};

        sys_rst = 1'b1;
        i_valid = 1'b0;
        i_wb    = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("rst_done", int'(o_done), 0);
        chk("rst_found", int'(o_found), 0);
        chk("rst_x1", int'(o_x1), 0);
        chk("rst_x2", int'(o_x2), 0);
        chk("rst_y1", int'(o_y1), 0);
        chk("rst_y2", int'(o_y2), 0);
        chk("rst_cnt", int'(o_cnt), 0);

        // Vector 3 is followed with no idle cycle, so vector 4's object cell (0,0)
        // arrives in the commit cycle.
        foreach (vecs[i]) begin
            send_frame(vecs[i], found_for(vecs[i].found));
            if (!vecs[i].b2b) idle(2);
        end
        idle(3);
        drain();

        // Reset after 20 object cells: the partial frame must produce no result.
        for (int i = 0; i < 20; i++) begin
            @(posedge sys_clk); #1;
            i_valid = 1'b1;
            i_wb    = 1'b0;
        end
        do_reset();
        @(negedge sys_clk);
        chk("midrst_found", int'(o_found), 0);
        chk("midrst_x2", int'(o_x2), 0);
        chk("midrst_cnt", int'(o_cnt), 0);
        send_frame(vrst, found_for(vrst.found));
        idle(3);
        drain();

`ifdef BBOX_DEBOUNCE_EN
        begin
            bit deb_exp [6];
            deb_exp = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
            do_reset();
            for (int i = 0; i < 6; i++) begin
                send_frame((i < 3) ? vecs[0] : vecs[1], deb_exp[i]);
                idle(1);
            end
            idle(3);
            drain();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d results pending", sb.size());
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/blob_bbox.md
Name: blob_bbox

Overview:
- Consumes the decimated binary cell stream produced by the corrosion stage (one cell per CORROSION_SIZE x CORROSION_SIZE block of the picture window).
- Per frame, locates object cells and reports their bounding box (cell coordinates), object cell count and a found flag.
- Feeds the target-position / UART reporting logic downstream.

Parameters:
- GRID_X, `CORROSION_DX, cells per row of the decimated grid
- GRID_Y, `CORROSION_DY, cell rows per frame
- CELL_W, 8, width of cell coordinates (must hold GRID_X-1 and GRID_Y-1)
- CNT_W, 16, width of object cell counter
- OBJ_LEVEL, 1'b0, i_wb value that marks an object cell (0 = dark after corrosion)
- MIN_CELLS, 4, minimum object cells in a frame for o_found
- DEB_FRAMES, 3, debounce depth (only used with BBOX_DEBOUNCE_EN)

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  synchronous reset, active-high
- i_valid  in  1  cell strobe from corrosion stage
- i_wb  in  1  cell value
- o_done  out  1  one-cycle pulse, new frame result on outputs
- o_found  out  1  object present in last reported frame
- o_x1  out  CELL_W  leftmost object cell column
- o_x2  out  CELL_W  rightmost object cell column
- o_y1  out  CELL_W  top object cell row
- o_y2  out  CELL_W  bottom object cell row
- o_cnt  out  CNT_W  object cell count of last frame

Behaviour:
- Reset is synchronous, active-high, and wins over everything. All outputs, counters, accumulators and seen flag are 0.
- Position counters cx (0..GRID_X-1) and cy (0..GRID_Y-1) advance only on i_valid. cx wraps to 0 after GRID_X-1 and increments cy. cy wraps to 0 after GRID_Y-1. i_valid gaps of any length are legal.
- Object cell = i_valid && i_wb == OBJ_LEVEL.
- Accumulators: min_x, max_x, min_y, max_y, acc_cnt, seen. The first object cell of a frame loads all four bounds with its cx/cy and sets seen. Later object cells update min/max and add to acc_cnt. acc_cnt saturates at all-ones and does not wrap.
- States:
  - ACCUM: default state. Accumulates cells.
  - COMMIT: entered for exactly one cycle on the cycle after the last cell (cx=GRID_X-1, cy=GRID_Y-1, i_valid). Returns unconditionally to ACCUM.
- The last cell itself is included in the result; its own contribution is folded in before commit.
- Commit cycle actions:
  - o_done=1.
  - o_x1/o_x2/o_y1/o_y2/o_cnt are loaded from the accumulators.
  - Raw found = seen && acc_cnt >= MIN_CELLS.
  - Empty frame (seen=0): all coordinates and o_cnt are 0, raw found=0.
  - Accumulators clear in the same cycle.
- Latency: o_done is 1 cycle after the last-cell i_valid. Outputs hold until the next o_done.
- An i_valid arriving in the COMMIT cycle is the first cell of the next frame. It is accumulated into the freshly cleared accumulators and not lost; the first-cell load overrides the clear.
- o_done is 0 in every cycle except COMMIT.
- Reset mid-frame: partial frame is discarded, counters restart at cell (0,0). No o_done is produced for the partial frame.

Optional Feature:
- Macro: BBOX_DEBOUNCE_EN.
- Defined:
  - o_found is a debounced version of raw found.
  - A saturating hit counter and a miss counter (width clog2(DEB_FRAMES+1)) are updated each commit.
  - o_found rises after DEB_FRAMES consecutive raw-found frames and falls after DEB_FRAMES consecutive raw-miss frames.
  - The opposite counter clears on each commit.
  - Coordinates and o_cnt still update every frame.
- Not defined: o_found equals raw found of the last commit; no extra registers.

Test Plan:
(Bench parameters: GRID_X=8, GRID_Y=6, MIN_CELLS=2, DEB_FRAMES=3, OBJ_LEVEL=0.)
- Single frame, object cells at (2,1),(5,1),(3,4) -> one o_done pulse 1 cycle after 48th i_valid; x1=2, x2=5, y1=1, y2=4, cnt=3, found=1.
- All-background frame (i_wb=1 everywhere) -> o_done; x1=x2=y1=y2=0, cnt=0, found=0.
- Single object cell at (7,5), the last cell of the frame -> cnt=1, bounds 7/7/5/5, found=0 (below MIN_CELLS).
- Back-to-back frames: valid held high continuously, first cell (0,0) of frame 2 is an object -> frame 2 reports x1=0, y1=0, and cell (0,0) is counted.
- sys_rst pulsed after 20 cells, then full frame with object at (1,1),(1,2) -> no o_done for the partial frame; next result x1=x2=1, y1=1, y2=2, cnt=2, found=1.
- With BBOX_DEBOUNCE_EN: frame pattern found,found,found,miss,miss,miss -> o_found is 0,0,1,1,1,0 at successive o_done.
